imem_loader: RTL and testbench

//  Boot-time program loader upstream of the mips core. Receives a byte stream
//  (valid/ready), assembles big-endian 32-bit words and writes them into the

---
 rtl/imem_loader.sv | 207 ++++++++++++++++++++
 tb/tb_imem_loader.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: boot-time program loader for the mips core.
// Takes a byte stream framed as LEN_HI, LEN_LO, 4*N payload bytes (MSB first)
// and CSUM. It packs the payload into big-endian 32-bit words, writes each word
// into the instruction memory, and holds the core in reset until a complete
// image with a matching checksum has been loaded.

module imem_loader #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_rst,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [2:0] {
        ST_LEN_HI = 3'd0,
        ST_LEN_LO = 3'd1,
        ST_DATA   = 3'd2,
        ST_CSUM   = 3'd3,
        ST_DONE   = 3'd4,
        ST_ERROR  = 3'd5
    } state_e;

    // Architectural state and its next-state values.
    state_e            state_q,    state_d;
    logic [15:0]       len_q,      len_d;       // word count N from the header
    logic [23:0]       word_q,     word_d;      // first three bytes of the word in progress
    logic [1:0]        byte_cnt_q, byte_cnt_d;  // byte position inside the current word
    logic [7:0]        csum_q,     csum_d;      // running mod-256 sum of header and payload
    logic              we_q,       we_d;
    logic [ADDR_W-1:0] addr_q,     addr_d;
    logic [31:0]       wdata_q,    wdata_d;
    logic [ADDR_W:0]   words_q,    words_d;     // words written; also the next word index
    logic              done_q,     done_d;
    logic              error_q,    error_d;
    logic              cpu_rst_q,  cpu_rst_d;

    // Helper terms used by the next-state logic.
    logic              accept;
    logic [15:0]       len_full;
    logic [ADDR_W:0]   words_inc;
    logic              len_too_big;
    logic              last_word;

    // Only the loading states take bytes; DONE/ERROR wait for start instead.
    assign in_ready    = (state_q != ST_DONE) && (state_q != ST_ERROR);
    assign accept      = in_valid && in_ready;

    // Complete length as it stands once LEN_LO is on the bus.
    assign len_full    = {len_q[15:8], in_data};
    assign len_too_big = 32'(len_full) > 32'(DEPTH);

    // The word being completed now is the last one when the count reaches N.
    assign words_inc   = words_q + (ADDR_W+1)'(1);
    assign last_word   = 32'(words_inc) == 32'(len_q);

    // Registered outputs: every output except in_ready comes straight from a flop.
    assign imem_we      = we_q;
    assign imem_addr    = addr_q;
    assign imem_wdata   = wdata_q;
    assign cpu_rst      = cpu_rst_q;
    assign done         = done_q;
    assign error        = error_q;
    assign words_loaded = words_q;

    // State register: synchronous reset returns every register to its boot value.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments here so every flop samples the
        // pre-edge values; blocking ones would chain updates within one edge.
        if (rst) begin
            state_q    <= ST_LEN_HI;
            len_q      <= '0;
            word_q     <= '0;
            byte_cnt_q <= '0;
            csum_q     <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            words_q    <= '0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            cpu_rst_q  <= 1'b1;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            word_q     <= word_d;
            byte_cnt_q <= byte_cnt_d;
            csum_q     <= csum_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            words_q    <= words_d;
            done_q     <= done_d;
            error_q    <= error_d;
            cpu_rst_q  <= cpu_rst_d;
        end
    end

    // Next-state and output logic for the frame parser.
    always_comb begin
        // NOTE: every _d gets a default before the case statement; a path that
        // left one unassigned would infer a latch.
        state_d    = state_q;
        len_d      = len_q;
        word_d     = word_q;
        byte_cnt_d = byte_cnt_q;
        csum_d     = csum_q;
        we_d       = 1'b0;             // write strobe is a one-cycle pulse
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        words_d    = words_q;
        done_d     = done_q;
        error_d    = error_q;
        cpu_rst_d  = cpu_rst_q;

        unique case (state_q)
            ST_LEN_HI: begin
                if (accept) begin
                    len_d   = {in_data, 8'h00};
                    csum_d  = csum_q + in_data;
                    state_d = ST_LEN_LO;
                end
            end

            ST_LEN_LO: begin
                if (accept) begin
                    len_d  = len_full;
                    csum_d = csum_q + in_data;
                    if (len_too_big) begin
                        // Image cannot fit: refuse it before touching memory.
                        state_d = ST_ERROR;
                        error_d = 1'b1;
                    end else if (len_full == 16'd0) begin
                        state_d = ST_CSUM;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end

            ST_DATA: begin
                if (accept) begin
                    csum_d     = csum_q + in_data;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        // Fourth byte completes the word; write it next cycle.
                        we_d    = 1'b1;
                        wdata_d = {word_q, in_data};
                        addr_d  = words_q[ADDR_W-1:0];
                        words_d = words_inc;
                        word_d  = '0;
                        if (last_word) begin
                            state_d = ST_CSUM;
                        end
                    end else begin
                        word_d = {word_q[15:0], in_data};
                    end
                end
            end

            ST_CSUM: begin
                if (accept) begin
                    if (in_data == csum_q) begin
                        state_d   = ST_DONE;
                        done_d    = 1'b1;
                        cpu_rst_d = 1'b0;      // release the core
                    end else begin
                        state_d = ST_ERROR;
                        error_d = 1'b1;
                    end
                end
            end

            ST_DONE, ST_ERROR: begin
                if (start) begin
                    // Reload: clear all per-load bookkeeping and re-hold the core.
                    state_d    = ST_LEN_HI;
                    len_d      = '0;
                    word_d     = '0;
                    byte_cnt_d = '0;
                    csum_d     = '0;
                    words_d    = '0;
                    done_d     = 1'b0;
                    error_d    = 1'b0;
                    cpu_rst_d  = 1'b1;
                end
            end

            default: begin
                state_d = ST_LEN_HI;
            end
        endcase
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: frames are built from word patterns,
// expected memory writes are queued as payload is driven and compared as the
// DUT's write strobe fires.

module tb_imem_loader;

    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_rst;
    logic              done;
    logic              error;
    logic [ADDR_W:0]   words_loaded;

    imem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .cpu_rst      (cpu_rst),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         mon_exp;
    logic [31:0] img [0:15];
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %08h expected %08h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Scoreboard side: every write strobe must match the oldest queued write.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", {22'd0, imem_addr}, 32'hFFFF_FFFF);
            end else begin
                mon_exp = exp_q.pop_front();
                check("wr_addr", 32'(imem_addr), 32'(mon_exp.addr));
                check("wr_data", imem_wdata, mon_exp.data);
            end
        end
    end

    // Word pattern: seed 0 selects the hand-written image table.
    function automatic logic [31:0] pat(input int seed, input int i);
        if (seed == 0) return img[i];
        return (32'h9E37_79B9 * 32'(i + 1)) ^ 32'(seed);
    endfunction

    function automatic int gap_of(input int max_gap);
        if (max_gap == 0) return 0;
        return int'($urandom_range(0, max_gap));
    endfunction

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Offer one byte after 'gap' idle cycles; return right after the accepting edge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int waited;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
        in_data  = b;
        in_valid = 1'b1;
        waited   = 0;
        while (in_ready !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 50) check("accept_timeout", 32'(waited), 32'd0);
        @(posedge clk);
    endtask

    // Drive a whole frame; abort_after >= 0 stops after that many payload bytes.
    task automatic run_frame(input logic [15:0] len, input int seed, input logic [7:0] csum_flip,
                             input int max_gap, input int abort_after);
        logic [7:0]  csum;
        logic [31:0] w;
        logic [7:0]  b;
        int          sent;
        csum = 8'd0;
        sent = 0;
        send_byte(len[15:8], gap_of(max_gap));
        csum = csum + len[15:8];
        send_byte(len[7:0], gap_of(max_gap));
        csum = csum + len[7:0];
        if (32'(len) > 32'(DEPTH)) begin
            idle();
            return;
        end
        for (int i = 0; i < int'(len); i++) begin
            w = pat(seed, i);
            for (int j = 3; j >= 0; j--) begin
                if (sent == abort_after) begin
                    idle();
                    return;
                end
                b = w[j*8 +: 8];
                send_byte(b, gap_of(max_gap));
                csum = csum + b;
                sent++;
            end
            exp_q.push_back('{addr: ADDR_W'(i), data: w});
        end
        send_byte(csum ^ csum_flip, gap_of(max_gap));
        idle();
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic expect_status(input string tag, input logic exp_done, input logic exp_err,
                                 input int exp_words);
        check({tag, "_done"},    32'(done),         32'(exp_done));
        check({tag, "_error"},   32'(error),        32'(exp_err));
        check({tag, "_cpu_rst"}, 32'(cpu_rst),      32'(!exp_done));
        check({tag, "_ready"},   32'(in_ready),     32'(!(exp_done || exp_err)));
        check({tag, "_words"},   32'(words_loaded), 32'(exp_words));
        check({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #600_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready",   32'(in_ready),     32'd1);
        check("rst_we",      32'(imem_we),      32'd0);
        check("rst_addr",    32'(imem_addr),    32'd0);
        check("rst_wdata",   imem_wdata,        32'd0);
        check("rst_cpu_rst", 32'(cpu_rst),      32'd1);
        check("rst_done",    32'(done),         32'd0);
        check("rst_error",   32'(error),        32'd0);
        check("rst_words",   32'(words_loaded), 32'd0);
        rst = 1'b0;

        // Two-word image with a correct checksum.
        img[0] = 32'h2008_0005;
        img[1] = 32'h0000_0000;
        run_frame(16'd2, 0, 8'h00, 0, -1);
        expect_status("t1", 1'b1, 1'b0, 2);
        // Bytes offered in DONE are ignored: no writes, status unchanged.
        @(negedge clk);
        in_data  = 8'hAA;
        in_valid = 1'b1;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        expect_status("t1_hold", 1'b1, 1'b0, 2);
        pulse_start();
        expect_status("t1_restart", 1'b0, 1'b0, 0);

        // Same image, checksum off by one.
        run_frame(16'd2, 0, 8'h01, 0, -1);
        expect_status("t2", 1'b0, 1'b1, 2);
        pulse_start();
        expect_status("t2_restart", 1'b0, 1'b0, 0);

        // Length one past the memory depth is rejected right after LEN_LO.
        run_frame(16'h0401, 1, 8'h00, 0, -1);
        expect_status("t3", 1'b0, 1'b1, 0);
        pulse_start();

        // Empty image, good then bad checksum.
        run_frame(16'd0, 1, 8'h00, 0, -1);
        expect_status("t4_ok", 1'b1, 1'b0, 0);
        pulse_start();
        run_frame(16'd0, 1, 8'h01, 0, -1);
        expect_status("t4_bad", 1'b0, 1'b1, 0);
        pulse_start();

        // Full-depth image: last address DEPTH-1, word count DEPTH.
        run_frame(16'(DEPTH), 77, 8'h00, 0, -1);
        expect_status("t_full", 1'b1, 1'b0, DEPTH);
        pulse_start();

        // Eight words gapless, then the same words with random valid gaps and a
        // start pulse mid-load that must be ignored.
        run_frame(16'd8, 5, 8'h00, 0, -1);
        expect_status("t5_gapless", 1'b1, 1'b0, 8);
        pulse_start();
        fork
            run_frame(16'd8, 5, 8'h00, 3, -1);
            begin
                repeat (12) @(negedge clk);
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
        join
        expect_status("t5_gaps", 1'b1, 1'b0, 8);
        pulse_start();

        // Reset after six payload bytes, then a clean one-word frame.
        run_frame(16'd2, 9, 8'h00, 0, 6);
        check("t6_partial_pending", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t6_rst_we", 32'(imem_we), 32'd0);
        expect_status("t6_rst", 1'b0, 1'b0, 0);
        img[0] = 32'hDEAD_BEEF;
        run_frame(16'd1, 0, 8'h00, 0, -1);
        expect_status("t6", 1'b1, 1'b0, 1);

        // rst and start together in DONE: reset wins and clears everything.
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        expect_status("t7_rst_start", 1'b0, 1'b0, 0);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
